machine_counters: RTL and testbench

Holds the RV32 machine counters `mcycle` and `minstret` as 64-bit registers. It sits directly downstream of the counter-inhibit setup stage and consumes its registered `mcountinhibit` CY/IR bits to gate counting. It accepts CSR writes to the low and high halves from the CSR write path. It supplies counter values to the CSR read mux and the user-level shadows (`cycle`, `instret`).

---
 rtl/machine_counters_pkg.sv | 22 ++
 rtl/machine_counters_csr_counter64.sv | 31 +++
 rtl/machine_counters.sv | 70 +++++++
 tb/tb_machine_counters.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/machine_counters_pkg.sv
// Shared constants for the RV32 machine counters: CSR addresses, counter
// width and reset defaults.
package machine_counters_pkg;

  localparam int unsigned CNT_W = 64;

  localparam logic [11:0] MCYCLE_ADDR    = 12'hB00;
  localparam logic [11:0] MINSTRET_ADDR  = 12'hB02;
  localparam logic [11:0] MCYCLEH_ADDR   = 12'hB80;
  localparam logic [11:0] MINSTRETH_ADDR = 12'hB82;

  localparam logic [11:0] CYCLE_ADDR     = 12'hC00;
  localparam logic [11:0] INSTRET_ADDR   = 12'hC02;
  localparam logic [11:0] CYCLEH_ADDR    = 12'hC80;
  localparam logic [11:0] INSTRETH_ADDR  = 12'hC82;

  localparam logic [11:0] MCOUNTINHIBIT_ADDR = 12'h320;

  localparam logic [CNT_W-1:0] MCYCLE_RESET_DEFAULT   = '0;
  localparam logic [CNT_W-1:0] MINSTRET_RESET_DEFAULT = '0;

endpackage

// File: rtl/machine_counters_csr_counter64.sv
// 64-bit CSR counter: synchronous reset, low/high half writes and increment,
// in that priority order.
module csr_counter64
  import machine_counters_pkg::*;
#(
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic             inc,
  input  logic [31:0]      data_wr,
  output logic [CNT_W-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count <= RESET_VAL;
    end else if (wr_lo) begin
      count[31:0] <= data_wr;
    end else if (wr_hi) begin
      count[CNT_W-1:32] <= data_wr;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/machine_counters.sv
// RV32 mcycle/minstret counters with CSR write decode.
// Define MACHINE_COUNTERS_CSR_READ_EN to build the 32-bit CSR read mux.
module machine_counters
  import machine_counters_pkg::*;
#(
  parameter logic [CNT_W-1:0] MCYCLE_RESET   = MCYCLE_RESET_DEFAULT,
  parameter logic [CNT_W-1:0] MINSTRET_RESET = MINSTRET_RESET_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             wr_en_in,
  input  logic [11:0]      csr_addr_in,
  input  logic [31:0]      data_wr_in,
  input  logic             mcountinhibit_cy_in,
  input  logic             mcountinhibit_ir_in,
  input  logic             instret_in,
  output logic [CNT_W-1:0] mcycle_out,
  output logic [CNT_W-1:0] minstret_out,
  output logic [31:0]      csr_data_out
);

  logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;
  logic inc_cycle, inc_instret;

  // Shadow addresses are read-only, so only the machine addresses decode writes.
  assign wr_mcycle    = wr_en_in && (csr_addr_in == MCYCLE_ADDR);
  assign wr_mcycleh   = wr_en_in && (csr_addr_in == MCYCLEH_ADDR);
  assign wr_minstret  = wr_en_in && (csr_addr_in == MINSTRET_ADDR);
  assign wr_minstreth = wr_en_in && (csr_addr_in == MINSTRETH_ADDR);

  assign inc_cycle   = !mcountinhibit_cy_in;
  assign inc_instret = instret_in && !mcountinhibit_ir_in;

  csr_counter64 #(.RESET_VAL(MCYCLE_RESET)) u_mcycle (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_lo   (wr_mcycle),
    .wr_hi   (wr_mcycleh),
    .inc     (inc_cycle),
    .data_wr (data_wr_in),
    .count   (mcycle_out)
  );

  csr_counter64 #(.RESET_VAL(MINSTRET_RESET)) u_minstret (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_lo   (wr_minstret),
    .wr_hi   (wr_minstreth),
    .inc     (inc_instret),
    .data_wr (data_wr_in),
    .count   (minstret_out)
  );

`ifdef MACHINE_COUNTERS_CSR_READ_EN
  // NOTE: the default assignment ahead of the case keeps this mux latch-free.
  always_comb begin
    csr_data_out = '0;
    case (csr_addr_in)
      MCYCLE_ADDR,    CYCLE_ADDR:    csr_data_out = mcycle_out[31:0];
      MCYCLEH_ADDR,   CYCLEH_ADDR:   csr_data_out = mcycle_out[CNT_W-1:32];
      MINSTRET_ADDR,  INSTRET_ADDR:  csr_data_out = minstret_out[31:0];
      MINSTRETH_ADDR, INSTRETH_ADDR: csr_data_out = minstret_out[CNT_W-1:32];
      default:                       csr_data_out = '0;
    endcase
  end
`else
  assign csr_data_out = '0;
`endif

endmodule

// File: tb/tb_machine_counters.sv
// Self-checking bench for machine_counters: a directed vector table, corner
// sequences and randomized traffic against a behavioural reference model.
module tb_machine_counters;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        wr_en_in = 1'b0;
  logic [11:0] csr_addr_in = 12'h0;
  logic [31:0] data_wr_in = 32'h0;
  logic        mcountinhibit_cy_in = 1'b0;
  logic        mcountinhibit_ir_in = 1'b0;
  logic        instret_in = 1'b0;
  logic [63:0] mcycle_out, minstret_out;
  logic [31:0] csr_data_out;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [63:0] m_cyc = 64'h0;
  logic [63:0] m_ins = 64'h0;

  machine_counters dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .wr_en_in            (wr_en_in),
    .csr_addr_in         (csr_addr_in),
    .data_wr_in          (data_wr_in),
    .mcountinhibit_cy_in (mcountinhibit_cy_in),
    .mcountinhibit_ir_in (mcountinhibit_ir_in),
    .instret_in          (instret_in),
    .mcycle_out          (mcycle_out),
    .minstret_out        (minstret_out),
    .csr_data_out        (csr_data_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [11:0] a);
`ifdef MACHINE_COUNTERS_CSR_READ_EN
    case (a)
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      default:          return 32'h0;
    endcase
`else
    return 32'h0;
`endif
  endfunction

  task automatic drive(input logic rst, input logic wr, input logic [11:0] addr,
                       input logic [31:0] data, input logic icy, input logic iir,
                       input logic ir);
    rst_in = rst; wr_en_in = wr; csr_addr_in = addr; data_wr_in = data;
    mcountinhibit_cy_in = icy; mcountinhibit_ir_in = iir; instret_in = ir;
  endtask

  // Advance one edge and apply the counter rules to the model.
  task automatic step();
    @(posedge clk_in);
    if (rst_in) begin
      m_cyc = 64'h0;
      m_ins = 64'h0;
    end else begin
      if (wr_en_in && csr_addr_in == 12'hB00)      m_cyc = {m_cyc[63:32], data_wr_in};
      else if (wr_en_in && csr_addr_in == 12'hB80) m_cyc = {data_wr_in, m_cyc[31:0]};
      else if (!mcountinhibit_cy_in)               m_cyc = m_cyc + 64'd1;
      if (wr_en_in && csr_addr_in == 12'hB02)      m_ins = {m_ins[63:32], data_wr_in};
      else if (wr_en_in && csr_addr_in == 12'hB82) m_ins = {data_wr_in, m_ins[31:0]};
      else if (instret_in && !mcountinhibit_ir_in) m_ins = m_ins + 64'd1;
    end
    #1;
  endtask

  task automatic idle(input logic ir);
    drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, ir);
  endtask

  typedef struct {
    logic        rst;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic        icy;
    logic        iir;
    logic        ir;
    logic [63:0] exp_cyc;
    logic [63:0] exp_ins;
  } vec_t;

  vec_t vecs[13];
  logic [11:0] addr_pool[10];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 64'h0, 64'h0};
    vecs[1]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b1, 64'h1, 64'h1};
    vecs[2]  = '{1'b0, 1'b1, 12'hB00, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h2};
    vecs[3]  = '{1'b0, 1'b1, 12'hB80, 32'h0,        1'b0, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h2};
    vecs[4]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 64'h2};
    vecs[5]  = '{1'b0, 1'b1, 12'hC00, 32'h1234,     1'b0, 1'b0, 1'b1, 64'h0000_0001_0000_0001, 64'h3};
    vecs[6]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b1, 1'b0, 1'b1, 64'h0000_0001_0000_0001, 64'h4};
    vecs[7]  = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b1, 1'b1, 64'h0000_0001_0000_0002, 64'h4};
    vecs[8]  = '{1'b0, 1'b1, 12'hB82, 32'h1,        1'b0, 1'b0, 1'b1, 64'h0000_0001_0000_0003, 64'h0000_0001_0000_0004};
    vecs[9]  = '{1'b1, 1'b1, 12'hB00, 32'hAA,       1'b0, 1'b0, 1'b1, 64'h0, 64'h0};
    vecs[10] = '{1'b0, 1'b1, 12'hB02, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 64'h1, 64'h0000_0000_FFFF_FFFF};
    vecs[11] = '{1'b0, 1'b1, 12'hB82, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[12] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 1'b1, 64'h3, 64'h0};
    addr_pool = '{12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00,
                  12'hC02, 12'hC80, 12'hC82, 12'h320, 12'h7C0};

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].addr, vecs[i].data,
            vecs[i].icy, vecs[i].iir, vecs[i].ir);
      step();
      check($sformatf("vec%0d_mcycle", i), mcycle_out, vecs[i].exp_cyc);
      check($sformatf("vec%0d_minstret", i), minstret_out, vecs[i].exp_ins);
    end

    // Reset then ten counting cycles.
    drive(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    idle(1'b1);
    repeat (10) step();
    check("count10_mcycle", mcycle_out, 64'd10);
    check("count10_minstret", minstret_out, 64'd10);

    // Inhibit cycle counting at 5 for four cycles; minstret keeps going.
    drive(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    repeat (5) step();
    check("pre_inhibit_mcycle", mcycle_out, 64'd5);
    drive(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("inhibit%0d_mcycle", i), mcycle_out, 64'd5);
      check($sformatf("inhibit%0d_minstret", i), minstret_out, 64'(i));
    end
    idle(1'b0);
    step();
    check("resume_mcycle", mcycle_out, 64'd6);

    // High-half write on a retiring cycle suppresses the increment.
    drive(1'b0, 1'b1, 12'hB02, 32'd7, 1'b0, 1'b0, 1'b1);
    step();
    check("minstret_set7", minstret_out, 64'd7);
    drive(1'b0, 1'b1, 12'hB82, 32'h1, 1'b0, 1'b0, 1'b1);
`ifdef MACHINE_COUNTERS_CSR_READ_EN
    check("read_old_on_write", {32'h0, csr_data_out}, 64'h0);
`endif
    step();
    check("minstreth_write", minstret_out, 64'h0000_0001_0000_0007);
    idle(1'b1);
    step();
    check("minstreth_inc", minstret_out, 64'h0000_0001_0000_0008);

`ifdef MACHINE_COUNTERS_CSR_READ_EN
    drive(1'b0, 1'b1, 12'hB80, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    csr_addr_in = 12'hB80;
    #1;
    check("read_mcycleh", {32'h0, csr_data_out}, {32'h0, 32'hCAFE_0001});
    csr_addr_in = 12'hC80;
    #1;
    check("read_cycleh_alias", {32'h0, csr_data_out}, {32'h0, 32'hCAFE_0001});
`endif

    // Randomized traffic against the model.
    drive(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            addr_pool[$urandom_range(0, 9)], $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)));
      #1;
      check($sformatf("rnd%0d_read", i), {32'h0, csr_data_out}, {32'h0, ref_read(csr_addr_in)});
      step();
      check($sformatf("rnd%0d_mcycle", i), mcycle_out, m_cyc);
      check($sformatf("rnd%0d_minstret", i), minstret_out, m_ins);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
